// File: rtl/serial_add_sequencer.sv
// Bit-serial adder: one full_adder cell reused over WIDTH clocks, LSB first, with start/busy/done handshake.
// Optional `SERIAL_ADD_OVF_EN adds a registered two's-complement overflow flag (port ovf).

module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Y,
    output logic Cout
);
    assign Y    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_add_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Operand shifters plus the running carry, loaded together on an accepted start.
    typedef struct packed {
        logic [WIDTH-1:0] sha;
        logic [WIDTH-1:0] shb;
        logic             carry;
    } opnd_t;

    state_t           state, state_n;
    opnd_t            op;
    logic [WIDTH-1:0] shr;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             fa_y, fa_co;

    assign last = (cnt == CW'(WIDTH-1));

    full_adder u_fa (
        .A   (op.sha[0]),
        .B   (op.shb[0]),
        .Cin (op.carry),
        .Y   (fa_y),
        .Cout(fa_co)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (last)  state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // busy/done are registered from the next state so they line up with RUN/DONE exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_n == RUN);
            done <= (state_n == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op   <= '0;
            shr  <= '0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op.sha   <= a;
                        op.shb   <= b;
                        op.carry <= cin;
                        shr      <= '0;
                        cnt      <= '0;
                    end
                end
                RUN: begin
                    op.sha   <= op.sha >> 1;
                    op.shb   <= op.shb >> 1;
                    op.carry <= fa_co;
                    shr      <= {fa_y, shr[WIDTH-1:1]};
                    cnt      <= cnt + CW'(1);
                    // Commit on the MSB cycle so the result is visible while done is high.
                    if (last) begin
                        sum  <= {fa_y, shr[WIDTH-1:1]};
                        cout <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
                        // op.carry here is still the carry into the MSB.
                        ovf  <= op.carry ^ fa_co;
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer (WIDTH=4): vector table, random vs. arithmetic model, corner sequences.

module tb_serial_add_sequencer;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset, start, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_add_sequencer #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
`ifdef SERIAL_ADD_OVF_EN
        .ovf  (ovf),
`endif
        .cout (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a, b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int r;
        r = int'(x) + int'(y) + int'(c);
        return r[W:0];
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int sx, sy, r;
        sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
        sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
        r  = sx + sy + int'(c);
        return (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
    endfunction

    // Launch from IDLE and watch 8 cycles; cycle 1 is the cycle after the start edge.
    task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tc,
                           output logic [W-1:0] s, output logic co, output logic ov,
                           output int busy_cnt, output int done_cyc, output int done_cnt,
                           output bit held);
        logic [W-1:0] prev_s;
        logic         prev_co;
        prev_s = sum; prev_co = cout;
        a = ta; b = tb2; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = ~ta; b = ~tb2; cin = ~tc;   // operands changing during RUN must not matter
        busy_cnt = 0; done_cyc = -1; done_cnt = 0; held = 1'b1;
        s = 'x; co = 1'bx; ov = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (busy && (sum !== prev_s || cout !== prev_co)) held = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = i;
                    s = sum; co = cout;
`ifdef SERIAL_ADD_OVF_EN
                    ov = ovf;
`endif
                end
            end
        end
    endtask

    vec_t         vecs[6];
    logic [W-1:0] s;
    logic         co, ov;
    int           bc, dcyc, dcnt;
    bit           held;
    logic [W:0]   exp;
    int           dlist[$];

    initial begin
        vecs[0] = '{4'd3,  4'd5,  1'b0, 4'd8,  1'b0, 1'b0};
        vecs[1] = '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b0};
        vecs[2] = '{4'd7,  4'd7,  1'b1, 4'd15, 1'b0, 1'b1};
        vecs[3] = '{4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b1};
        vecs[4] = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b0};
        vecs[5] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0};

        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_sum",  sum,  0);
        chk("reset_cout", cout, 0);
`ifdef SERIAL_ADD_OVF_EN
        chk("reset_ovf",  ovf,  0);
`endif

        // Directed table
        for (int i = 0; i < 6; i++) begin
            run_add(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, ov, bc, dcyc, dcnt, held);
            chk($sformatf("vec%0d_sum", i),  s,    vecs[i].s);
            chk($sformatf("vec%0d_cout", i), co,   vecs[i].co);
            chk($sformatf("vec%0d_busy", i), bc,   W);
            chk($sformatf("vec%0d_dcyc", i), dcyc, W + 1);
            chk($sformatf("vec%0d_dcnt", i), dcnt, 1);
            chk($sformatf("vec%0d_held", i), held, 1);
`ifdef SERIAL_ADD_OVF_EN
            chk($sformatf("vec%0d_ovf", i),  ov,   vecs[i].ov);
`endif
        end

        // Random operands vs. arithmetic model
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] ra, rb;
            logic         rc;
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = W'($urandom_range(0, (1 << W) - 1));
            rc = 1'($urandom_range(0, 1));
            exp = model_add(ra, rb, rc);
            run_add(ra, rb, rc, s, co, ov, bc, dcyc, dcnt, held);
            chk($sformatf("rnd%0d_sum", i),  s,    exp[W-1:0]);
            chk($sformatf("rnd%0d_cout", i), co,   exp[W]);
            chk($sformatf("rnd%0d_dcyc", i), dcyc, W + 1);
`ifdef SERIAL_ADD_OVF_EN
            chk($sformatf("rnd%0d_ovf", i),  ov,   model_ovf(ra, rb, rc));
`endif
        end

        // Start during RUN is ignored; previous result held until done
        run_add(4'd1, 4'd1, 1'b0, s, co, ov, bc, dcyc, dcnt, held);
        a = 4'd2; b = 4'd2; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        dcnt = 0; dcyc = -1; held = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 2) begin
                a = 4'd9; b = 4'd9; start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
                @(negedge clk);
                i++;
            end
            if (busy && sum !== 4'd2) held = 1'b0;
            if (done) begin dcnt++; if (dcyc < 0) dcyc = i; end
        end
        chk("ign_dcnt", dcnt, 1);
        chk("ign_dcyc", dcyc, W + 1);
        chk("ign_sum",  sum,  4);
        chk("ign_held", held, 1);

        // Reset mid-RUN aborts, no done, results cleared
        a = 4'd6; b = 4'd6; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_sum",  sum,  0);
        chk("rst_cout", cout, 0);
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        chk("rst_nodone", dcnt, 0);
        run_add(4'd6, 4'd6, 1'b0, s, co, ov, bc, dcyc, dcnt, held);
        chk("rst_after_sum",  s,    12);
        chk("rst_after_dcyc", dcyc, W + 1);

        // Reset and start together: reset wins
        reset = 1'b1; start = 1'b1;
        @(posedge clk); #1 reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rststart_busy", busy, 0);
        @(negedge clk);
        chk("rststart_busy2", busy, 0);

        // Start held high: one launch every W+2 cycles
        a = 4'd1; b = 4'd2; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done) begin
                dlist.push_back(i);
                chk($sformatf("held_sum_c%0d", i), sum, 3);
            end
        end
        start = 1'b0;
        chk("held_ndone", dlist.size(), 2);
        if (dlist.size() == 2) begin
            chk("held_done0", dlist[0], W + 1);
            chk("held_done1", dlist[1], 2 * W + 3);
        end
        repeat (8) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
- Bit-serial adder controller: time-multiplexes one existing `full_adder` cell (ports A, B, Cin, Y, Cout) across a WIDTH-bit operand pair, one bit per clock, LSB first.
- Replaces a ripple chain of WIDTH full adders with one cell, a bit counter and shift registers.
- Sits between switch/operand sources and LED/result sinks.
- Start/busy/done handshake so a top level can launch additions and read results.

Parameters:
- WIDTH, 4, operand and sum width in bits (legal 2..16).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous active-high reset
- start  input  1  request a new addition; sampled only in IDLE
- a  input  WIDTH  operand A, captured on the accepted start
- b  input  WIDTH  operand B, captured on the accepted start
- cin  input  1  carry-in, captured on the accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when a result is committed
- sum  output  WIDTH  last committed sum
- cout  output  1  last committed carry-out

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, port name reset. Reset is evaluated before all other logic.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, bit counter=0, internal shift regs=0, carry reg=0.
- States:
  - IDLE: start=1 moves to RUN. Latch a, b into shift regs, cin into carry reg, clear counter.
  - RUN: each cycle, drive the full_adder with shA[0], shB[0] and the carry reg. Shift Y into the MSB of the result shift reg (right shift). Store Cout into the carry reg. Shift shA and shB right. Increment counter. When counter == WIDTH-1 on the current cycle, go to DONE.
  - DONE: copy the result shift reg to sum and the carry reg to cout. done=1 for this cycle only. Go to IDLE.
- Latency: start sampled at edge 0 → busy=1 during cycles 1..WIDTH → done=1 and new sum/cout visible in cycle WIDTH+1. Total WIDTH+1 cycles. The next start is accepted in the cycle after done.
- busy is a registered output, asserted exactly WIDTH cycles.
- sum and cout change only on DONE entry. They hold the previous result throughout RUN.
- start while in RUN or DONE: ignored, with no queueing. Operands changing during RUN have no effect.
- start held high continuously: a new addition launches every WIDTH+2 cycles (IDLE, RUN×WIDTH, DONE).
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No saturation.
- reset mid-RUN: abort immediately. No done pulse. sum and cout return to 0.
- reset and start asserted together: reset wins, state stays IDLE.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit), reset value 0, updated only on DONE.
  - ovf = carry into MSB XOR carry out of MSB, i.e. two's-complement signed overflow. Capture the carry reg value before the final bit cycle.
  - ovf clears on reset and on the next DONE without overflow.
- Undefined:
  - Port ovf is absent and no overflow logic is synthesised.
  - All other behaviour is identical.

Test Plan (WIDTH=4):
- reset, then a=3, b=5, cin=0, start pulse → busy high exactly 4 cycles; done pulse in cycle 5; sum=8, cout=0.
- a=15, b=1, cin=0 → sum=0, cout=1; with SERIAL_ADD_OVF_EN, ovf=0.
- a=7, b=7, cin=1 → sum=15, cout=0; with SERIAL_ADD_OVF_EN, ovf=1. Also a=7, b=1 → sum=8, ovf=1.
- Launch a=2, b=2; pulse start again at RUN cycle 2 with a=9, b=9 → second start ignored; sum=4, single done pulse; sum held at the previous value until done.
- Launch a=6, b=6; assert reset at RUN cycle 2 → next cycle busy=0, done never pulses, sum=0, cout=0. A new start then gives the correct result.
- start held high for 12 cycles with a=1, b=2 → done pulses at cycles 5 and 11 (period 6); sum=3 each time.
